// File: rtl/scanline_sched.sv
// Per-line scheduler for the scanline darkening datapath.
// Tracks hsync/vsync and counts lines plus a repeating pattern phase. Drives the
// 3-bit darkening code for the current line. Config is taken over valid/ready and
// held in a shadow copy until the next frame start, so no frame mixes two settings.
// Ports:
//   clk, reset            video clock, async active-high reset
//   hs_in, vs_in, de_in   video timing (active high)
//   cfg_valid/cfg_ready   config handshake (ready = no config pending)
//   cfg_level/period/dark/alt  offered config fields
//   level                 darkening code for the current line
//   line_cnt              active lines completed in this frame (saturating)
//   frame_odd             frame parity, toggles at each frame start
module scanline_sched #(
  parameter int unsigned LCW    = 11,
  parameter bit          ALT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic           de_in,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_level,
  input  logic [2:0]     cfg_period,
  input  logic [2:0]     cfg_dark,
  input  logic           cfg_alt,
  output logic [2:0]     level,
  output logic [LCW-1:0] line_cnt,
  output logic           frame_odd
);

  typedef struct packed {
    logic       alt;
    logic [2:0] dark;
    logic [2:0] period;
    logic [2:0] level;
  } cfg_t;

  localparam cfg_t CFG_RST = '{alt: 1'b0, dark: 3'd0, period: 3'd1, level: 3'd0};

  // Period 0 is treated as 1 so the phase counter always has a valid wrap point.
  function automatic logic [2:0] period_eff_f(input cfg_t c);
    return (c.period == 3'd0) ? 3'd1 : c.period;
  endfunction

  // Darkening code for a given phase under a given config.
  function automatic logic [2:0] code_f(input cfg_t c, input logic [2:0] ph);
    logic [2:0] pe;
    logic [2:0] de;
    logic [2:0] le;
    pe = period_eff_f(c);
    de = (c.dark > pe) ? pe : c.dark;
    le = (c.level > 3'd4) ? 3'd4 : c.level;
    return (ph < de) ? le : 3'd0;
  endfunction

  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           had_de_q, had_de_d;
  logic           pending_q, pending_d;
  logic           cfg_ready_q, cfg_ready_d;
  logic           frame_odd_q, frame_odd_d;
  logic [2:0]     phase_q, phase_d;
  logic [2:0]     level_q, level_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  cfg_t           active_q, active_d;
  cfg_t           shadow_q, shadow_d;

  logic           hs_fall, vs_fall, xfer;
  cfg_t           cfg_in, act_new;
  logic [2:0]     phase_nxt;

  // Next-state logic: frame start takes priority over line end.
  always_comb begin
    hs_fall     = hs_q & ~hs_in;
    vs_fall     = vs_q & ~vs_in;
    xfer        = cfg_valid & cfg_ready_q;
    cfg_in      = '{alt: cfg_alt, dark: cfg_dark, period: cfg_period, level: cfg_level};
    act_new     = active_q;
    phase_nxt   = 3'd0;

    hs_d        = hs_in;
    vs_d        = vs_in;
    had_de_d    = hs_fall ? 1'b0 : (had_de_q | de_in);
    pending_d   = pending_q;
    cfg_ready_d = cfg_ready_q;
    frame_odd_d = frame_odd_q;
    phase_d     = phase_q;
    level_d     = level_q;
    line_cnt_d  = line_cnt_q;
    active_d    = active_q;
    shadow_d    = shadow_q;

    if (vs_fall) begin
      if (pending_q) begin
        act_new     = shadow_q;
        pending_d   = 1'b0;
        cfg_ready_d = 1'b1;
      end
      active_d    = act_new;
      frame_odd_d = ~frame_odd_q;
      line_cnt_d  = '0;
      // Odd frames start one phase in when alternation is on; a 1-line period wraps to 0.
      if (ALT_EN && act_new.alt && frame_odd_d && (period_eff_f(act_new) > 3'd1)) begin
        phase_nxt = 3'd1;
      end
      phase_d = phase_nxt;
      level_d = code_f(act_new, phase_nxt);
    end else if (hs_fall) begin
      if (had_de_q && (line_cnt_q != '1)) begin
        line_cnt_d = line_cnt_q + LCW'(1);
      end
      phase_nxt = (phase_q == (period_eff_f(active_q) - 3'd1)) ? 3'd0 : (phase_q + 3'd1);
      phase_d   = phase_nxt;
      level_d   = code_f(active_q, phase_nxt);
    end

    // A transfer always lands in the shadow, even in the frame-start cycle.
    if (xfer) begin
      shadow_d    = cfg_in;
      pending_d   = 1'b1;
      cfg_ready_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      had_de_q    <= 1'b0;
      pending_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      frame_odd_q <= 1'b0;
      phase_q     <= 3'd0;
      level_q     <= 3'd0;
      line_cnt_q  <= '0;
      active_q    <= CFG_RST;
      shadow_q    <= '0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      had_de_q    <= had_de_d;
      pending_q   <= pending_d;
      cfg_ready_q <= cfg_ready_d;
      frame_odd_q <= frame_odd_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      line_cnt_q  <= line_cnt_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign level     = level_q;
  assign line_cnt  = line_cnt_q;
  assign frame_odd = frame_odd_q;

endmodule

// File: tb/tb_scanline_sched.sv
// Directed bench for scanline_sched: frames of 8 active lines, config handshake
// timing, clamping of out-of-range config, alternating phase, async reset and
// line counter saturation.
module tb_scanline_sched;

  localparam int unsigned LCW = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic           hs_in, vs_in, de_in;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_level, cfg_period, cfg_dark;
  logic           cfg_alt;
  logic [2:0]     level;
  logic [LCW-1:0] line_cnt;
  logic           frame_odd;

  int vectors     = 0;
  int miscompares = 0;

  scanline_sched #(.LCW(LCW), .ALT_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_level  (cfg_level),
    .cfg_period (cfg_period),
    .cfg_dark   (cfg_dark),
    .cfg_alt    (cfg_alt),
    .level      (level),
    .line_cnt   (line_cnt),
    .frame_odd  (frame_odd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cfg packing: {alt, dark[2:0], period[2:0], level[2:0]}
  task automatic drive_cfg(input logic [9:0] c);
    cfg_level  = c[2:0];
    cfg_period = c[5:3];
    cfg_dark   = c[8:6];
    cfg_alt    = c[9];
  endtask

  // One line: active video, then an hsync pulse whose falling edge ends the line.
  task automatic run_line(input string tag, input int idx, input logic [2:0] exp_lvl);
    de_in = 1'b1;
    tick();
    chk($sformatf("%s.l%0d", tag, idx), 32'(level), 32'(exp_lvl));
    tick(); tick(); tick();
    de_in = 1'b0;
    tick();
    hs_in = 1'b1;
    tick(); tick();
    hs_in = 1'b0;
    tick();
  endtask

  // mode 0: no config, 1: config offered before line 3, 2: config offered on the vs_fall cycle
  task automatic run_frame(input string tag, input logic [23:0] pat, input logic exp_odd,
                           input logic exp_rdy, input int mode, input logic [9:0] c);
    vs_in = 1'b1;
    tick(); tick();
    vs_in = 1'b0;
    if (mode == 2) begin
      drive_cfg(c);
      cfg_valid = 1'b1;
    end
    tick();
    cfg_valid = 1'b0;
    chk({tag, ".odd"}, 32'(frame_odd), 32'(exp_odd));
    chk({tag, ".cnt0"}, 32'(line_cnt), 32'd0);
    chk({tag, ".rdy"}, 32'(cfg_ready), 32'(exp_rdy));
    for (int i = 0; i < 8; i++) begin
      if (mode == 1 && i == 3) begin
        drive_cfg(c);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk({tag, ".rdy_lo"}, 32'(cfg_ready), 32'd0);
      end
      run_line(tag, i, pat[3*i +: 3]);
    end
    chk({tag, ".cnt8"}, 32'(line_cnt), 32'd8);
  endtask

  // Patterns list line 7 first, line 0 in the low bits.
  localparam logic [23:0] P_ZERO = 24'd0;
  localparam logic [23:0] P_ALT2 = {3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2};
  localparam logic [23:0] P_BLK  = {8{3'd4}};
  localparam logic [23:0] P_EVN  = {3'd0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3};
  localparam logic [23:0] P_ODD  = {3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0};

  localparam logic [9:0] C_P2  = {1'b0, 3'd1, 3'd2, 3'd2};
  localparam logic [9:0] C_CLP = {1'b0, 3'd5, 3'd0, 3'd7};
  localparam logic [9:0] C_ALT = {1'b1, 3'd1, 3'd3, 3'd3};
  localparam logic [9:0] C_RST = {1'b0, 3'd1, 3'd1, 3'd1};

  initial begin
    reset = 1'b1;
    hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    cfg_valid = 1'b0;
    drive_cfg(10'd0);
    tick(); tick();
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.cnt", 32'(line_cnt), 32'd0);
    chk("rst.odd", 32'(frame_odd), 32'd0);
    chk("rst.rdy", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    tick();

    // No config: all lines undarkened, parity toggles each frame.
    run_frame("f1", P_ZERO, 1'b1, 1'b1, 0, 10'd0);
    run_frame("f2", P_ZERO, 1'b0, 1'b1, 0, 10'd0);
    run_frame("f3", P_ZERO, 1'b1, 1'b1, 0, 10'd0);

    // Mid-frame config only takes effect at the next frame.
    run_frame("f4", P_ZERO, 1'b0, 1'b1, 1, C_P2);
    chk("f4.rdy_end", 32'(cfg_ready), 32'd0);
    run_frame("f5", P_ALT2, 1'b1, 1'b1, 0, 10'd0);

    // Config offered on the frame-start cycle waits one more frame; clamped values give all-black.
    run_frame("f6", P_ALT2, 1'b0, 1'b0, 2, C_CLP);
    run_frame("f7", P_BLK, 1'b1, 1'b1, 1, C_ALT);

    // Alternation: even frame starts at phase 0, odd frame at phase 1.
    run_frame("f8", P_EVN, 1'b0, 1'b1, 0, 10'd0);
    run_frame("f9", P_ODD, 1'b1, 1'b1, 0, 10'd0);
    chk("f9.wrap_level", 32'(level), 32'd3);

    // Async reset mid-line with a pending config.
    drive_cfg(C_RST);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("r6.rdy_lo", 32'(cfg_ready), 32'd0);
    de_in = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("r6.level", 32'(level), 32'd0);
    chk("r6.cnt", 32'(line_cnt), 32'd0);
    chk("r6.odd", 32'(frame_odd), 32'd0);
    chk("r6.rdy", 32'(cfg_ready), 32'd1);
    tick();
    reset = 1'b0;
    de_in = 1'b0;
    tick();
    run_frame("f10", P_ZERO, 1'b1, 1'b1, 0, 10'd0);

    // Line counter saturates at all-ones.
    for (int i = 0; i < 2039; i++) begin
      de_in = 1'b1; tick();
      de_in = 1'b0; hs_in = 1'b1; tick();
      hs_in = 1'b0; tick();
    end
    chk("sat.reach", 32'(line_cnt), 32'd2047);
    for (int i = 0; i < 3; i++) begin
      de_in = 1'b1; tick();
      de_in = 1'b0; hs_in = 1'b1; tick();
      hs_in = 1'b0; tick();
    end
    chk("sat.hold", 32'(line_cnt), 32'd2047);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
